// File: rtl/sd_bidir_pio_if.sv
// Avalon-MM slave bus bundle for sd_bidir_pio: register access plus level interrupt.
interface sd_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/sd_bidir_pio.sv
// Bidirectional PIO for SD-card DAT/CMD pads: per-bit direction, synchronised inputs,
// edge capture with masked level IRQ, and atomic set/clear of output bits.
module sd_bidir_pio #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  sd_bidir_pio_if.slave    bus,
  inout  wire [WIDTH-1:0]  bidir_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] data_dir_q, data_dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] prev_in_q, prev_in_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_hit;
  logic [31:0]      readdata_q, readdata_d;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign prev_in_d = sync_in;

  always_comb begin
    sync_d[0] = bidir_port;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_comb begin
    edge_hit = sync_in ^ prev_in_q;
    if (EDGE_TYPE == 0) begin
      edge_hit = sync_in & ~prev_in_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~sync_in & prev_in_q;
    end
  end

  // A fresh edge is OR-ed in after the W1C so it survives a same-cycle clear.
  always_comb begin
    data_out_d = data_out_q;
    data_dir_d = data_dir_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:   data_out_d = wd;
        ADDR_DIR:    data_dir_d = wd;
        ADDR_MASK:   irq_mask_d = wd;
        ADDR_EDGE:   edge_cap_d = edge_cap_q & ~wd;
        ADDR_OUTSET: data_out_d = data_out_q | wd;
        ADDR_OUTCLR: data_out_d = data_out_q & ~wd;
        default:     ;
      endcase
    end
    edge_cap_d = edge_cap_d | edge_hit;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d = zext(sync_in);
      ADDR_DIR:  readdata_d = zext(data_dir_q);
      ADDR_MASK: readdata_d = zext(irq_mask_q);
      ADDR_EDGE: readdata_d = zext(edge_cap_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      data_dir_q <= RESET_DIR;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      prev_in_q  <= '0;
      readdata_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      data_dir_q <= data_dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      prev_in_q  <= prev_in_d;
      readdata_q <= readdata_d;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_sd_bidir_pio.sv
// Self-checking bench for sd_bidir_pio: randomized traffic against a behavioural model
// on a 4-bit rising-edge instance, plus directed checks on falling/any-edge builds.
module tb_sd_bidir_pio;

  localparam int S_A = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic reset_n_b = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_bidir_pio_if bus_a ();
  sd_bidir_pio_if bus_b ();
  sd_bidir_pio_if bus_c ();

  wire  [3:0] pad_a;
  wire  [7:0] pad_b;
  wire  [3:0] pad_c;
  logic [3:0] tb_val_a = 4'h0;
  logic [3:0] tb_val_b = 4'hA;
  logic [3:0] tb_val_c = 4'h0;

  sd_bidir_pio #(.WIDTH(4), .SYNC_STAGES(S_A), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .bidir_port(pad_a)
  );

  sd_bidir_pio #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2),
                 .RESET_DIR(8'h0F), .RESET_OUT(8'h05)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .bus(bus_b), .bidir_port(pad_b)
  );

  sd_bidir_pio #(.WIDTH(4), .SYNC_STAGES(4), .EDGE_TYPE(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c), .bidir_port(pad_c)
  );

  // Behavioural model of dut_a: register values plus a history of pad samples.
  logic [3:0]  m_out  = '0;
  logic [3:0]  m_dir  = '0;
  logic [3:0]  m_mask = '0;
  logic [3:0]  m_edge = '0;
  logic [31:0] m_rd   = '0;
  logic [3:0]  m_hist [0:S_A];
  logic [3:0]  m_pad_now, m_rise, m_wd;
  logic        m_wr;

  for (genvar i = 0; i < 4; i++) begin : g_drv_a
    assign pad_a[i] = m_dir[i] ? 1'bz : tb_val_a[i];
  end
  assign pad_b[7:4] = tb_val_b;
  assign pad_c      = tb_val_c;

  assign m_pad_now = (m_dir & m_out) | (~m_dir & tb_val_a);
  assign m_rise    = m_hist[S_A-1] & ~m_hist[S_A];
  assign m_wr      = bus_a.chipselect && !bus_a.write_n;
  assign m_wd      = bus_a.writedata[3:0];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out  <= '0;
      m_dir  <= '0;
      m_mask <= '0;
      m_edge <= '0;
      m_rd   <= '0;
      for (int k = 0; k <= S_A; k++) m_hist[k] <= '0;
    end else begin
      case (bus_a.address)
        3'd0:    m_rd <= {28'd0, m_hist[S_A-1]};
        3'd1:    m_rd <= {28'd0, m_dir};
        3'd2:    m_rd <= {28'd0, m_mask};
        3'd3:    m_rd <= {28'd0, m_edge};
        default: m_rd <= 32'd0;
      endcase
      m_edge <= (m_wr && bus_a.address == 3'd3) ? ((m_edge & ~m_wd) | m_rise)
                                                 : (m_edge | m_rise);
      if (m_wr) begin
        case (bus_a.address)
          3'd0:    m_out  <= m_wd;
          3'd1:    m_dir  <= m_wd;
          3'd2:    m_mask <= m_wd;
          3'd4:    m_out  <= m_out | m_wd;
          3'd5:    m_out  <= m_out & ~m_wd;
          default: ;
        endcase
      end
      m_hist[0] <= m_pad_now;
      for (int k = 1; k <= S_A; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      check_output("model_rd_a",  bus_a.readdata, m_rd);
      check_output("model_irq_a", {31'd0, bus_a.irq}, {31'd0, |(m_edge & m_mask)});
      check_output("model_pad_a", {28'd0, pad_a}, {28'd0, m_pad_now});
    end
  end

  task automatic drive_bus(input int sel, input logic [2:0] addr, input logic cs,
                           input logic wn, input logic [31:0] wdat);
    case (sel)
      0: begin bus_a.address = addr; bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = wdat; end
      1: begin bus_b.address = addr; bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = wdat; end
      default: begin bus_c.address = addr; bus_c.chipselect = cs; bus_c.write_n = wn; bus_c.writedata = wdat; end
    endcase
  endtask

  function automatic logic [31:0] rd_of(input int sel);
    case (sel)
      0:       return bus_a.readdata;
      1:       return bus_b.readdata;
      default: return bus_c.readdata;
    endcase
  endfunction

  task automatic bus_write(input int sel, input logic [2:0] addr, input logic [31:0] wdat);
    drive_bus(sel, addr, 1'b1, 1'b0, wdat);
    @(negedge clk);
    drive_bus(sel, 3'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic bus_read(input int sel, input logic [2:0] addr, output logic [31:0] data);
    drive_bus(sel, addr, 1'b1, 1'b1, 32'd0);
    @(negedge clk);
    data = rd_of(sel);
    drive_bus(sel, 3'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      bus_a.address    = 3'($urandom_range(0, 7));
      bus_a.chipselect = 1'($urandom_range(0, 1));
      bus_a.write_n    = ($urandom_range(0, 2) != 0);
      bus_a.writedata  = $urandom;
      if ($urandom_range(0, 7) == 0) tb_val_a = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    drive_bus(0, 3'd0, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    drive_bus(0, 3'd0, 1'b0, 1'b1, 32'd0);
    drive_bus(1, 3'd0, 1'b0, 1'b1, 32'd0);
    drive_bus(2, 3'd0, 1'b0, 1'b1, 32'd0);
    #1;
    reset_n   = 1'b0;
    reset_n_b = 1'b0;
    #2;
    check_output("b_reset_pads", {24'd0, pad_b}, 32'h0000_00A5);
    check_output("b_reset_irq", {31'd0, bus_b.irq}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset values on dut_a
    for (int a = 0; a < 6; a++) begin
      bus_read(0, 3'(a), d);
      check_output($sformatf("a_reset_rd%0d", a), d, 32'd0);
    end
    check_output("a_reset_irq", {31'd0, bus_a.irq}, 32'd0);

    // Output set/clear and DATA latency
    bus_write(0, 3'd1, 32'hF);
    bus_write(0, 3'd0, 32'hFFFF_FFFA);
    bus_write(0, 3'd4, 32'h1);
    bus_write(0, 3'd5, 32'h8);
    check_output("a_pads_setclr", {28'd0, pad_a}, 32'h3);
    @(negedge clk);
    @(negedge clk);
    check_output("a_data_early", bus_a.readdata, 32'hB);
    @(negedge clk);
    check_output("a_data_latency", bus_a.readdata, 32'h3);

    // Rising edge capture and W1C with irq
    bus_write(0, 3'd1, 32'h0);
    repeat (4) @(negedge clk);
    bus_write(0, 3'd3, 32'hF);
    bus_write(0, 3'd2, 32'h4);
    tb_val_a[2] = 1'b1;
    repeat (2) @(negedge clk);
    check_output("a_irq_before", {31'd0, bus_a.irq}, 32'd0);
    @(negedge clk);
    check_output("a_irq_edge", {31'd0, bus_a.irq}, 32'd1);
    bus_read(0, 3'd3, d);
    check_output("a_edge_cap", d, 32'h4);
    bus_write(0, 3'd3, 32'h4);
    check_output("a_irq_cleared", {31'd0, bus_a.irq}, 32'd0);
    bus_read(0, 3'd3, d);
    check_output("a_edge_cleared", d, 32'h0);

    // Edge beats a same-cycle W1C
    tb_val_a[1] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(0, 3'd3, d);
    check_output("a_edge_bit1", d, 32'h2);
    tb_val_a[1] = 1'b0;
    repeat (4) @(negedge clk);
    tb_val_a[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(0, 3'd3, 32'h2);
    bus_read(0, 3'd3, d);
    check_output("a_edge_wins", d, 32'h2);
    bus_write(0, 3'd3, 32'h2);
    bus_read(0, 3'd3, d);
    check_output("a_edge_w1c", d, 32'h0);

    apply_stimulus(1500);
    repeat (4) @(negedge clk);

    // Falling-edge build: only the trailing edge of a pulse is captured
    bus_write(2, 3'd2, 32'h1);
    tb_val_c = 4'h1;
    repeat (8) @(negedge clk);
    bus_read(2, 3'd0, d);
    check_output("c_data", d, 32'h1);
    bus_read(2, 3'd3, d);
    check_output("c_no_rise", d, 32'h0);
    check_output("c_irq_low", {31'd0, bus_c.irq}, 32'd0);
    tb_val_c = 4'h0;
    repeat (8) @(negedge clk);
    bus_read(2, 3'd3, d);
    check_output("c_fall", d, 32'h1);
    check_output("c_irq_high", {31'd0, bus_c.irq}, 32'd1);
    bus_write(2, 3'd3, 32'h1);
    bus_read(2, 3'd3, d);
    check_output("c_w1c", d, 32'h0);

    // Any-edge build with non-zero reset values
    reset_n_b = 1'b1;
    repeat (6) @(negedge clk);
    bus_read(1, 3'd1, d);
    check_output("b_dir_reset", d, 32'h0F);
    bus_read(1, 3'd0, d);
    check_output("b_data", d, 32'hA5);
    bus_read(1, 3'd3, d);
    check_output("b_release_rise", d, 32'hA5);
    bus_write(1, 3'd3, 32'hFF);
    bus_read(1, 3'd3, d);
    check_output("b_w1c_all", d, 32'h0);
    tb_val_b = 4'hB;
    repeat (6) @(negedge clk);
    bus_read(1, 3'd3, d);
    check_output("b_any_rise", d, 32'h10);
    bus_write(1, 3'd3, 32'h10);
    bus_read(1, 3'd3, d);
    check_output("b_between", d, 32'h0);
    tb_val_b = 4'hA;
    repeat (6) @(negedge clk);
    bus_read(1, 3'd3, d);
    check_output("b_any_fall", d, 32'h10);
    bus_write(1, 3'd2, 32'h10);
    check_output("b_irq", {31'd0, bus_b.irq}, 32'd1);
    bus_write(1, 3'd4, 32'h0A);
    check_output("b_outset", {24'd0, pad_b}, 32'hAF);

    // Reset asserted in the middle of a write
    drive_bus(1, 3'd1, 1'b1, 1'b0, 32'hFF);
    #2;
    reset_n_b = 1'b0;
    #1;
    check_output("b_midrst_pads", {24'd0, pad_b}, 32'hA5);
    check_output("b_midrst_irq", {31'd0, bus_b.irq}, 32'd0);
    check_output("b_midrst_rd", bus_b.readdata, 32'd0);
    drive_bus(1, 3'd0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    reset_n_b = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(1, 3'd1, d);
    check_output("b_dir_after", d, 32'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
